// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer for the 8-bit single-cycle core.
// Streams a program into imem, holds the core in reset while loading, then
// gates execution per cycle: free run, single step, halt on command,
// halt on PC breakpoint, or halt when the cycle budget runs out.
module cpu_run_ctrl #(
    parameter int IMEM_DEPTH = 16,
    parameter int AW         = 4,
    parameter int DW         = 8,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    input  logic             ld_valid,
    input  logic [DW-1:0]    ld_data,
    output logic             ld_ready,
    output logic             imem_we,
    output logic [AW-1:0]    imem_waddr,
    output logic [DW-1:0]    imem_wdata,
    input  logic [AW-1:0]    core_pc,
    input  logic             bp_en,
    input  logic [AW-1:0]    bp_addr,
    output logic             core_en,
    output logic             core_rst,
    output logic [2:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    localparam logic [1:0] CAUSE_STEP    = 2'd0;
    localparam logic [1:0] CAUSE_CMD     = 2'd1;
    localparam logic [1:0] CAUSE_BP      = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CYC_SAT   = '1;
    localparam logic [AW-1:0]    LAST_ADDR = AW'(IMEM_DEPTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] ld_cnt;
    logic          run_first;
    logic          cmd_acc;
    logic          ld_acc;
    logic          halt_req;
    logic          bp_hit;
    logic          timeout_hit;
    logic          load_start;
    logic          exec_start;
    logic          cyc_clear;
    logic          cause_we;
    logic [1:0]    cause_d;

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALT);
    assign ld_ready  = (state_q == ST_LOAD);
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign ld_acc    = ld_valid & ld_ready;
    assign state     = state_q;

    // Stop conditions; the breakpoint is ignored on the first RUN cycle so a
    // resume from the breakpoint PC executes that instruction.
    always_comb begin
        halt_req    = cmd_acc && (cmd == CMD_HALT);
        bp_hit      = bp_en && (core_pc == bp_addr) && !run_first;
        timeout_hit = (MAX_CYCLES != 0) && (cyc_cnt == CYC_LIMIT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the per-cycle execute gate and control strobes.
    always_comb begin
        state_d    = state_q;
        core_en    = 1'b0;
        load_start = 1'b0;
        exec_start = 1'b0;
        cyc_clear  = 1'b0;
        cause_we   = 1'b0;
        cause_d    = CAUSE_STEP;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (cmd_acc) begin
                    case (cmd)
                        CMD_LOAD: begin
                            state_d    = ST_LOAD;
                            load_start = 1'b1;
                            cyc_clear  = 1'b1;
                        end
                        CMD_RUN: begin
                            state_d    = ST_RUN;
                            exec_start = 1'b1;
                            cyc_clear  = (state_q == ST_HALT) && (halt_cause == CAUSE_TIMEOUT);
                        end
                        CMD_STEP: begin
                            state_d    = ST_STEP;
                            exec_start = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (ld_acc && (ld_cnt == LAST_ADDR)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d  = ST_HALT;
                    cause_we = 1'b1;
                    cause_d  = CAUSE_CMD;
                end else if (bp_hit) begin
                    state_d  = ST_HALT;
                    cause_we = 1'b1;
                    cause_d  = CAUSE_BP;
                end else if (timeout_hit) begin
                    state_d  = ST_HALT;
                    cause_we = 1'b1;
                    cause_d  = CAUSE_TIMEOUT;
                end else begin
                    core_en = 1'b1;
                end
            end
            ST_STEP: begin
                core_en  = 1'b1;
                state_d  = ST_HALT;
                cause_we = 1'b1;
                cause_d  = CAUSE_STEP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Program streaming: register each accepted byte into an imem write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            ld_cnt     <= '0;
        end else begin
            imem_we <= ld_acc;
            if (ld_acc) begin
                imem_waddr <= ld_cnt;
                imem_wdata <= ld_data;
                ld_cnt     <= ld_cnt + 1'b1;
            end
            if (load_start) begin
                ld_cnt <= '0;
            end
        end
    end

    // Core reset, halt cause and first-RUN-cycle tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            core_rst   <= 1'b1;
            halt_cause <= CAUSE_STEP;
            run_first  <= 1'b1;
        end else begin
            if (load_start) begin
                core_rst <= 1'b1;
            end else if (exec_start) begin
                core_rst <= 1'b0;
            end
            if (cause_we) begin
                halt_cause <= cause_d;
            end
            run_first <= (state_q != ST_RUN);
        end
    end

    // Saturating count of executed cycles since the last LOAD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_cnt <= '0;
        end else if (cyc_clear) begin
            cyc_cnt <= '0;
        end else if (core_en && (cyc_cnt != CYC_SAT)) begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: a stub core advances the PC whenever core_en
// is high, a behavioural model predicts every output each cycle, and a vector
// table plus directed sequences cover loading, breakpoints, stepping and timeout.
module tb_cpu_run_ctrl;

    localparam int MAXC   = 20;
    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_RUN  = 2;
    localparam int S_STEP = 3;
    localparam int S_HALT = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [7:0]  imem_wdata;
    logic [3:0]  core_pc;
    logic        bp_en;
    logic [3:0]  bp_addr;
    logic        core_en;
    logic        core_rst;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    logic [15:0] cyc_cnt;

    cpu_run_ctrl #(
        .IMEM_DEPTH(16),
        .AW(4),
        .DW(8),
        .CNT_W(16),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .cmd_ready(cmd_ready),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .ld_ready(ld_ready),
        .imem_we(imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .core_pc(core_pc),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .core_en(core_en),
        .core_rst(core_rst),
        .state(state),
        .halt_cause(halt_cause),
        .cyc_cnt(cyc_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, in plain integers.
    bit model_ok = 1'b0;
    int m_state, m_cause, m_cyc, m_ldn, m_run_age, m_waddr, m_wdata;
    bit m_core_rst, m_we;
    bit e_cmd_ready, e_ld_ready, e_core_en;
    int e_stop;

    // Stub core.
    logic [3:0] pc;
    bit         loop_prog;
    assign core_pc = pc;

    // Samples taken in the current cycle.
    logic [2:0] s_state;
    logic       s_core_en, s_core_rst, s_we, s_cmd_ready, s_ld_ready;
    logic [3:0] s_waddr;

    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         en_count;
    logic [7:0] prog [16];

    typedef struct {
        bit         r;
        bit         cv;
        logic [1:0] c;
        bit         lv;
        logic [7:0] d;
        logic [2:0] st;
        bit         crdy;
        bit         lrdy;
        bit         cen;
        bit         crst;
        bit         we;
        logic [3:0] wa;
    } vec_t;

    vec_t tbl [15];

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [3:0] nextPc(input logic [3:0] p);
        if (loop_prog && p >= 4'd3) return 4'd0;
        return p + 4'd1;
    endfunction

    task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic cv, input logic [1:0] c,
                                 input logic lv, input logic [7:0] d);
        rst       = r;
        cmd_valid = cv;
        cmd       = c;
        ld_valid  = lv;
        ld_data   = d;
    endtask

    // Combinational expectations for this cycle from the model state and inputs.
    task automatic modelComb();
        e_cmd_ready = (m_state == S_IDLE) || (m_state == S_RUN) || (m_state == S_HALT);
        e_ld_ready  = (m_state == S_LOAD);
        e_stop      = -1;
        e_core_en   = 1'b0;
        if (m_state == S_RUN) begin
            if (cmd_valid && cmd == 2'b11) e_stop = 1;
            else if (bp_en && core_pc == bp_addr && m_run_age > 0) e_stop = 2;
            else if (MAXC != 0 && m_cyc == MAXC) e_stop = 3;
            e_core_en = (e_stop < 0);
        end
        if (m_state == S_STEP) e_core_en = 1'b1;
    endtask

    // Advance the model across one clock edge.
    task automatic modelAdvance();
        if (!rst) begin
            m_state = S_IDLE; m_core_rst = 1'b1; m_we = 1'b0; m_waddr = 0; m_wdata = 0;
            m_cause = 0; m_cyc = 0; m_ldn = 0; m_run_age = 0; model_ok = 1'b1;
            return;
        end
        m_we = 1'b0;
        case (m_state)
            S_IDLE, S_HALT: begin
                if (cmd_valid) begin
                    if (cmd == 2'b00) begin
                        m_state = S_LOAD; m_ldn = 0; m_cyc = 0; m_core_rst = 1'b1;
                    end else if (cmd == 2'b01) begin
                        if (m_state == S_HALT && m_cause == 3) m_cyc = 0;
                        m_state = S_RUN; m_run_age = 0; m_core_rst = 1'b0;
                    end else if (cmd == 2'b10) begin
                        m_state = S_STEP; m_core_rst = 1'b0;
                    end
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    m_we = 1'b1; m_waddr = m_ldn; m_wdata = ld_data; m_ldn++;
                    if (m_ldn == 16) m_state = S_IDLE;
                end
            end
            S_RUN: begin
                m_run_age++;
                if (e_stop >= 0) begin
                    m_state = S_HALT; m_cause = e_stop;
                end
            end
            S_STEP: begin
                m_state = S_HALT; m_cause = 0;
            end
            default: ;
        endcase
        if (e_core_en && m_cyc < 65535) m_cyc++;
    endtask

    task automatic checkOutput();
        expectEq("state", state, m_state);
        expectEq("cmd_ready", cmd_ready, e_cmd_ready);
        expectEq("ld_ready", ld_ready, e_ld_ready);
        expectEq("core_en", core_en, e_core_en);
        expectEq("core_rst", core_rst, m_core_rst);
        expectEq("imem_we", imem_we, m_we);
        expectEq("imem_waddr", imem_waddr, m_waddr);
        expectEq("imem_wdata", imem_wdata, m_wdata);
        expectEq("halt_cause", halt_cause, m_cause);
        expectEq("cyc_cnt", cyc_cnt, m_cyc);
    endtask

    // One clock cycle: sample and check, advance model, then move the stub core.
    task automatic tick();
        #1;
        modelComb();
        s_state = state; s_core_en = core_en; s_core_rst = core_rst; s_we = imem_we;
        s_waddr = imem_waddr; s_cmd_ready = cmd_ready; s_ld_ready = ld_ready;
        if (model_ok) checkOutput();
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_waddr);
            wr_data_q.push_back(imem_wdata);
        end
        if (core_en === 1'b1) en_count++;
        modelAdvance();
        @(posedge clk);
        @(negedge clk);
        if (s_core_rst === 1'b1) pc = 4'd0;
        else if (s_core_en === 1'b1) pc = nextPc(pc);
    endtask

    task automatic cmdCycle(input logic [1:0] c);
        applyStimulus(1'b1, 1'b1, c, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
            tick();
        end
    endtask

    task automatic waitState(input string name, input logic [2:0] want, input int bound);
        int k;
        k = 0;
        while (state !== want && k < bound) begin
            applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
            tick();
            k++;
        end
        expectEq(name, state, want);
    endtask

    task automatic loadProgram();
        int  i;
        int  guard;
        bit  lv;
        cmdCycle(2'b00);
        i = 0;
        guard = 0;
        while (i < 16 && guard < 200) begin
            lv = ($urandom_range(0, 2) != 0);
            applyStimulus(1'b1, 1'b0, 2'b00, lv, prog[i]);
            tick();
            if (lv) i++;
            guard++;
        end
        idleCycles(1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clk = 1'b0;
        pc = 4'd0;
        loop_prog = 1'b0;
        bp_en = 1'b0;
        bp_addr = 4'd0;
        en_count = 0;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);

        //         r  cv  c      lv  d      st    crdy lrdy cen crst we wa
        tbl[0]  = '{1, 1, 2'd0, 0, 8'h00, 3'd0, 1, 0, 0, 1, 0, 4'd0};
        tbl[1]  = '{1, 0, 2'd0, 1, 8'h11, 3'd1, 0, 1, 0, 1, 0, 4'd0};
        tbl[2]  = '{1, 0, 2'd0, 0, 8'h00, 3'd1, 0, 1, 0, 1, 1, 4'd0};
        tbl[3]  = '{1, 0, 2'd0, 1, 8'h22, 3'd1, 0, 1, 0, 1, 0, 4'd0};
        tbl[4]  = '{1, 0, 2'd0, 1, 8'h33, 3'd1, 0, 1, 0, 1, 1, 4'd1};
        tbl[5]  = '{1, 0, 2'd0, 1, 8'h44, 3'd1, 0, 1, 0, 1, 1, 4'd2};
        tbl[6]  = '{1, 0, 2'd0, 1, 8'h55, 3'd1, 0, 1, 0, 1, 1, 4'd3};
        tbl[7]  = '{1, 0, 2'd0, 0, 8'h00, 3'd1, 0, 1, 0, 1, 1, 4'd4};
        tbl[8]  = '{0, 0, 2'd0, 0, 8'h00, 3'd1, 0, 1, 0, 1, 0, 4'd4};
        tbl[9]  = '{1, 0, 2'd0, 0, 8'h00, 3'd0, 1, 0, 0, 1, 0, 4'd0};
        tbl[10] = '{1, 1, 2'd1, 0, 8'h00, 3'd0, 1, 0, 0, 1, 0, 4'd0};
        tbl[11] = '{1, 1, 2'd3, 0, 8'h00, 3'd2, 1, 0, 0, 0, 0, 4'd0};
        tbl[12] = '{1, 1, 2'd2, 0, 8'h00, 3'd4, 1, 0, 0, 0, 0, 4'd0};
        tbl[13] = '{1, 1, 2'd0, 0, 8'h00, 3'd3, 0, 0, 1, 0, 0, 4'd0};
        tbl[14] = '{1, 0, 2'd0, 0, 8'h00, 3'd4, 1, 0, 0, 0, 0, 4'd0};

        @(negedge clk);

        // Reset values.
        tick();
        tick();
        expectEq("rst_state", state, S_IDLE);
        expectEq("rst_core_rst", core_rst, 1);
        expectEq("rst_imem_we", imem_we, 0);
        expectEq("rst_imem_waddr", imem_waddr, 0);
        expectEq("rst_imem_wdata", imem_wdata, 0);
        expectEq("rst_halt_cause", halt_cause, 0);
        expectEq("rst_cyc_cnt", cyc_cnt, 0);

        // Vector table: partial load abandoned by reset, readiness, run/halt/step.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].r, tbl[i].cv, tbl[i].c, tbl[i].lv, tbl[i].d);
            tick();
            expectEq($sformatf("vec%0d_state", i), s_state, tbl[i].st);
            expectEq($sformatf("vec%0d_cmd_ready", i), s_cmd_ready, tbl[i].crdy);
            expectEq($sformatf("vec%0d_ld_ready", i), s_ld_ready, tbl[i].lrdy);
            expectEq($sformatf("vec%0d_core_en", i), s_core_en, tbl[i].cen);
            expectEq($sformatf("vec%0d_core_rst", i), s_core_rst, tbl[i].crst);
            expectEq($sformatf("vec%0d_imem_we", i), s_we, tbl[i].we);
            expectEq($sformatf("vec%0d_imem_waddr", i), s_waddr, tbl[i].wa);
        end

        // Full 16-byte load with random ld_valid gaps.
        prog = '{8'h8A, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0,
                 8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78};
        wr_addr_q.delete();
        wr_data_q.delete();
        loadProgram();
        expectEq("t1_write_count", wr_addr_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < wr_addr_q.size()) begin
                expectEq($sformatf("t1_waddr%0d", i), wr_addr_q[i], i);
                expectEq($sformatf("t1_wdata%0d", i), wr_data_q[i], prog[i]);
            end
        end
        expectEq("t1_state", state, S_IDLE);
        expectEq("t1_core_rst", core_rst, 1);
        expectEq("t1_ld_ready", ld_ready, 0);

        // Breakpoint at PC 7 on straight-line code.
        loop_prog = 1'b0;
        bp_en = 1'b1;
        bp_addr = 4'd7;
        en_count = 0;
        cmdCycle(2'b01);
        waitState("t2_reach_halt", S_HALT, 40);
        expectEq("t2_halt_cause", halt_cause, 2);
        expectEq("t2_cyc_cnt", cyc_cnt, 7);
        expectEq("t2_pc", core_pc, 7);
        expectEq("t2_en_cycles", en_count, 7);

        // Single step from the breakpoint, then run past it and halt by command.
        en_count = 0;
        cmdCycle(2'b10);
        idleCycles(3);
        expectEq("t3_en_cycles", en_count, 1);
        expectEq("t3_cyc_cnt", cyc_cnt, 8);
        expectEq("t3_halt_cause", halt_cause, 0);
        expectEq("t3_pc", core_pc, 8);
        cmdCycle(2'b01);
        idleCycles(3);
        cmdCycle(2'b11);
        expectEq("t3_halt_en", s_core_en, 0);
        expectEq("t3_run_pc", core_pc, 11);
        expectEq("t3_run_cyc", cyc_cnt, 11);
        expectEq("t3_run_cause", halt_cause, 1);

        // Resume while sitting on the breakpoint PC: first cycle must execute.
        bp_addr = 4'd11;
        cmdCycle(2'b01);
        idleCycles(1);
        expectEq("t3_resume_pc", core_pc, 12);
        waitState("t3_reach_timeout", S_HALT, 40);
        expectEq("t3_timeout_cause", halt_cause, 3);
        expectEq("t3_timeout_cyc", cyc_cnt, 20);

        // Cycle-budget timeout on a looping program.
        prog = '{8'h10, 8'h21, 8'h32, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        loop_prog = 1'b1;
        bp_en = 1'b0;
        loadProgram();
        expectEq("t4_cyc_cleared_by_load", cyc_cnt, 0);
        en_count = 0;
        cmdCycle(2'b01);
        waitState("t4_reach_halt", S_HALT, 60);
        expectEq("t4_en_cycles", en_count, 20);
        expectEq("t4_halt_cause", halt_cause, 3);
        expectEq("t4_cyc_cnt", cyc_cnt, 20);
        cmdCycle(2'b01);
        expectEq("t4_rerun_state", state, S_RUN);
        expectEq("t4_rerun_cyc", cyc_cnt, 0);
        idleCycles(1);
        expectEq("t4_rerun_cyc_inc", cyc_cnt, 1);

        // HALT command in the same cycle as a breakpoint hit.
        bp_en = 1'b1;
        bp_addr = 4'd2;
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 20 && !hit; k++) begin
                if (pc == 4'd2) begin
                    cmdCycle(2'b11);
                    hit = 1'b1;
                end else begin
                    idleCycles(1);
                end
            end
            expectEq("t5_reached_bp", hit, 1);
        end
        expectEq("t5_core_en", s_core_en, 0);
        expectEq("t5_state", state, S_HALT);
        expectEq("t5_halt_cause", halt_cause, 1);
        expectEq("t5_pc", core_pc, 2);

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                bp_en = 1'($urandom_range(0, 1));
                bp_addr = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) == 0) loop_prog = ~loop_prog;
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 3) == 0),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          8'($urandom));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
